// File: rtl/axi_tagctrl_pkg.sv
// Shared types for the tag-controller read-response merge stage: configuration,
// descriptor / tag-response / R-beat layouts, FSM states and the tag index helper.
package axi_tagctrl_pkg;

   typedef struct packed {
      int unsigned BlockSize;
   } tagc_cfg_t;

   typedef struct packed {
      int unsigned AxiAddrWidth;
      int unsigned AxiDataWidth;
      int unsigned AxiIdWidth;
      int unsigned AxiUserWidth;
      int unsigned CapSize;
      tagc_cfg_t   tagc_cfg;
   } tagctrl_cfg_t;

   localparam tagctrl_cfg_t DefaultCfg = '{
      AxiAddrWidth: 32,
      AxiDataWidth: 128,
      AxiIdWidth:   4,
      AxiUserWidth: 1,
      CapSize:      128,
      tagc_cfg:     '{BlockSize: 64}
   };

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {IDLE, FETCH, STREAM} r_state_e;

   typedef struct packed {
      logic [DefaultCfg.AxiIdWidth-1:0]   a_x_id;
      logic [DefaultCfg.AxiAddrWidth-1:0] a_x_addr;
      logic [7:0]                         a_x_len;
      logic [2:0]                         a_x_size;
      logic [7:0]                         a_x_tag_len;
   } tagctrl_desc_s;

   typedef struct packed {
      logic [DefaultCfg.tagc_cfg.BlockSize-1:0] data;
      logic [1:0]                               resp;
      logic                                     last;
   } tagc_rsp_s;

   typedef struct packed {
      logic [DefaultCfg.AxiIdWidth-1:0]   id;
      logic [DefaultCfg.AxiDataWidth-1:0] data;
      logic [1:0]                         resp;
      logic                               last;
      logic [DefaultCfg.AxiUserWidth-1:0] user;
   } r_chan_s;

   // Position of the capability containing addr within its tag block.
   function automatic int unsigned tag_idx(input logic [63:0] addr,
                                           input int unsigned cap_size,
                                           input int unsigned block_size);
      return 32'((addr / 64'(cap_size / 8)) % 64'(block_size));
   endfunction

endpackage

// File: rtl/axi_tagctrl_r_tagsel.sv
// Combinational mapper from the current tag word to the per-capability user
// lanes of one R beat, given beat address and transfer size.
module axi_tagctrl_r_tagsel
   import axi_tagctrl_pkg::*;
#(
   parameter int unsigned DataWidth = 128,
   parameter int unsigned CapSize   = 128,
   parameter int unsigned BlockSize = 64,
   parameter int unsigned UserWidth = 1,
   parameter int unsigned AddrWidth = 32
) (
   input  logic [BlockSize-1:0] tag_word,
   input  logic [AddrWidth-1:0] addr,
   input  logic [2:0]           size,
   input  logic                 tag_err,
   output logic [UserWidth-1:0] user
);

   localparam int unsigned CapBytesLog2 = $clog2(CapSize / 8);
   localparam int unsigned IdxW         = $clog2(BlockSize);
   localparam int unsigned Lanes        = DataWidth / CapSize;
   localparam int unsigned LaneW        = (Lanes > 1) ? $clog2(Lanes) : 1;

   logic [IdxW-1:0]  idx;
   logic [LaneW-1:0] lane;
   logic             wide;
   int unsigned      beat_caps;

   assign idx       = IdxW'(tag_idx(64'(addr), CapSize, BlockSize));
   assign wide      = (32'(size) >= CapBytesLog2);
   assign beat_caps = wide ? (32'd1 << (32'(size) - CapBytesLog2)) : 32'd0;

   // Sub-capability transfers carry a single tag on the lane that holds the address.
   generate
      if (Lanes > 1) begin : g_lane_sel
         assign lane = addr[CapBytesLog2 +: LaneW];
      end else begin : g_lane_zero
         assign lane = '0;
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < UserWidth; gi++) begin : g_user
         if (gi < Lanes) begin : g_used
            localparam int unsigned K = gi;
            logic [IdxW-1:0] pos;
            assign pos = idx + IdxW'(K);
            assign user[gi] = !tag_err &&
                              (wide ? ((K < beat_caps) && tag_word[pos])
                                    : ((32'(lane) == K) && tag_word[idx]));
         end else begin : g_spare
            assign user[gi] = 1'b0;
         end
      end
   endgenerate

endmodule

// File: rtl/axi_tagctrl_r.sv
// Read-response merge stage: restores the original ID on memory R beats and attaches
// per-capability tags in r.user. Optional macro AXI_TAGCTRL_R_TAGERR_EN turns tag-read errors into SLVERR.
module axi_tagctrl_r
   import axi_tagctrl_pkg::*;
#(
   parameter tagctrl_cfg_t Cfg            = DefaultCfg,
   parameter type          tagctrl_desc_t = tagctrl_desc_s,
   parameter type          tagc_rsp_t     = tagc_rsp_s,
   parameter type          r_chan_t       = r_chan_s
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  tagctrl_desc_t tagctrl_desc_i,
   input  logic          tagctrl_valid_i,
   output logic          tagctrl_ready_o,
   input  tagc_rsp_t     tagc_rsp_i,
   input  logic          tagc_valid_i,
   output logic          tagc_ready_o,
   input  r_chan_t       r_mem_chan_i,
   input  logic          r_mem_valid_i,
   output logic          r_mem_ready_o,
   output r_chan_t       r_chan_slv_o,
   output logic          r_chan_valid_o,
   input  logic          r_chan_ready_i
);

   localparam int unsigned Aw   = Cfg.AxiAddrWidth;
   localparam int unsigned Iw   = Cfg.AxiIdWidth;
   localparam int unsigned Bs   = Cfg.tagc_cfg.BlockSize;
   localparam int unsigned Uw   = Cfg.AxiUserWidth;
   localparam int unsigned IdxW = $clog2(Bs);

   r_state_e        state;
   logic            desc_ready;
   logic            tagc_ready;
   logic            drain;
   logic            tag_err;
   logic [Iw-1:0]   id;
   logic [Aw-1:0]   addr;
   logic [Aw-1:0]   next_addr;
   logic [7:0]      beats_left;
   logic [7:0]      words_left;
   logic [2:0]      size;
   logic [Bs-1:0]   tag_word;
   logic [IdxW-1:0] next_idx;
   logic [Uw-1:0]   user;
   logic [1:0]      r_resp;
   logic            tag_err_sel;
   logic            beat_hs;

   assign next_addr = addr + (Aw'(1) << size);
   assign next_idx  = IdxW'(tag_idx(64'(next_addr), Cfg.CapSize, Bs));
   assign beat_hs   = (state == STREAM) && r_mem_valid_i && r_chan_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         desc_ready <= 1'b0;
         tagc_ready <= 1'b0;
         drain      <= 1'b0;
         tag_err    <= 1'b0;
         id         <= '0;
         addr       <= '0;
         beats_left <= '0;
         words_left <= '0;
         size       <= '0;
         tag_word   <= '0;
      end else begin
         case (state)
            IDLE: begin
               desc_ready <= 1'b1;
               if (tagctrl_valid_i && desc_ready) begin
                  id         <= tagctrl_desc_i.a_x_id;
                  addr       <= tagctrl_desc_i.a_x_addr;
                  beats_left <= tagctrl_desc_i.a_x_len;
                  size       <= tagctrl_desc_i.a_x_size;
                  words_left <= tagctrl_desc_i.a_x_tag_len;
                  drain      <= 1'b0;
                  desc_ready <= 1'b0;
                  tagc_ready <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               if (tagc_valid_i && tagc_ready) begin
                  if (drain) begin
                     // Leftover tag words after the last beat are consumed and dropped.
                     words_left <= words_left - 8'd1;
                     if (words_left == 8'd1) begin
                        drain      <= 1'b0;
                        tagc_ready <= 1'b0;
                        desc_ready <= 1'b1;
                        state      <= IDLE;
                     end
                  end else begin
                     tag_word   <= tagc_rsp_i.data;
                     tag_err    <= (tagc_rsp_i.resp != RESP_OKAY);
                     tagc_ready <= 1'b0;
                     state      <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (beat_hs) begin
                  addr       <= next_addr;
                  beats_left <= beats_left - 8'd1;
                  if (beats_left == 8'd0) begin
                     if (words_left == 8'd0) begin
                        desc_ready <= 1'b1;
                        state      <= IDLE;
                     end else begin
                        drain      <= 1'b1;
                        tagc_ready <= 1'b1;
                        state      <= FETCH;
                     end
                  end else if (next_idx == '0) begin
                     words_left <= words_left - 8'd1;
                     tagc_ready <= 1'b1;
                     state      <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXI_TAGCTRL_R_TAGERR_EN
   assign tag_err_sel = tag_err;
   assign r_resp      = (tag_err && !r_mem_chan_i.resp[1]) ? 2'b10 : r_mem_chan_i.resp;
`else
   assign tag_err_sel = 1'b0;
   assign r_resp      = r_mem_chan_i.resp;
`endif

   axi_tagctrl_r_tagsel #(
      .DataWidth (Cfg.AxiDataWidth),
      .CapSize   (Cfg.CapSize),
      .BlockSize (Bs),
      .UserWidth (Uw),
      .AddrWidth (Aw)
   ) u_tagsel (
      .tag_word (tag_word),
      .addr     (addr),
      .size     (size),
      .tag_err  (tag_err_sel),
      .user     (user)
   );

   assign tagctrl_ready_o = desc_ready;
   assign tagc_ready_o    = tagc_ready;
   assign r_chan_valid_o  = (state == STREAM) && r_mem_valid_i;
   assign r_mem_ready_o   = (state == STREAM) && r_chan_ready_i;

   always_comb begin
      r_chan_slv_o = '0;
      if (state == STREAM) begin
         r_chan_slv_o.id   = id;
         r_chan_slv_o.data = r_mem_chan_i.data;
         r_chan_slv_o.resp = r_resp;
         r_chan_slv_o.last = (beats_left == 8'd0);
         r_chan_slv_o.user = user;
      end
   end

   // Memory-side ID/last/user are superseded by the descriptor.
   logic unused_inputs;
   assign unused_inputs = ^{tagc_rsp_i.last, r_mem_chan_i.id, r_mem_chan_i.last,
                            r_mem_chan_i.user, tag_err};

endmodule

// File: tb/tb_axi_tagctrl_r.sv
// Directed scoreboard bench for axi_tagctrl_r (AxiDataWidth=128, CapSize=128, BlockSize=64).
`timescale 1ns/1ps
module tb_axi_tagctrl_r;
   import axi_tagctrl_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   tagctrl_desc_s desc = '0;
   logic          desc_valid = 1'b0;
   logic          desc_ready;
   tagc_rsp_s     tag_rsp = '0;
   logic          tag_valid = 1'b0;
   logic          tag_ready;
   r_chan_s       mem_r = '0;
   logic          mem_valid = 1'b0;
   logic          mem_ready;
   r_chan_s       slv_r;
   logic          slv_valid;
   logic          slv_ready = 1'b1;

   r_chan_s exp_q[$];
   r_chan_s mon_e;
   int      checks = 0;
   int      errors = 0;
   logic    done;
   logic [7:0] pattern;

   always #5 clk = ~clk;

   axi_tagctrl_r dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .tagctrl_desc_i  (desc),
      .tagctrl_valid_i (desc_valid),
      .tagctrl_ready_o (desc_ready),
      .tagc_rsp_i      (tag_rsp),
      .tagc_valid_i    (tag_valid),
      .tagc_ready_o    (tag_ready),
      .r_mem_chan_i    (mem_r),
      .r_mem_valid_i   (mem_valid),
      .r_mem_ready_o   (mem_ready),
      .r_chan_slv_o    (slv_r),
      .r_chan_valid_o  (slv_valid),
      .r_chan_ready_i  (slv_ready)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string what);
      checks++;
      errors++;
      $error("FAIL timeout_%s: observed no handshake expected handshake", what);
   endtask

   // Scoreboard: every slave-side beat is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && slv_valid) begin
         check("mem_ready_mirror", 256'(mem_ready), 256'(slv_ready));
         if (slv_ready) begin
            if (exp_q.size() == 0) begin
               check("beat_expected", 256'(exp_q.size()), 256'(1));
            end else begin
               mon_e = exp_q.pop_front();
               $display("beat id=%0h data=%0h resp=%0d last=%0d user=%0h", slv_r.id, slv_r.data,
                        slv_r.resp, slv_r.last, slv_r.user);
               check("beat_id",   256'(slv_r.id),   256'(mon_e.id));
               check("beat_data", 256'(slv_r.data), 256'(mon_e.data));
               check("beat_resp", 256'(slv_r.resp), 256'(mon_e.resp));
               check("beat_last", 256'(slv_r.last), 256'(mon_e.last));
               check("beat_user", 256'(slv_r.user), 256'(mon_e.user));
            end
         end
      end
   end

   task automatic send_desc(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [7:0] tlen);
      int n = 0;
      desc = '{a_x_id: id, a_x_addr: a, a_x_len: len, a_x_size: sz, a_x_tag_len: tlen};
      desc_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!desc_ready && n < 200);
      if (!desc_ready) timeout_fail("desc");
      @(posedge clk); #1;
      desc_valid = 1'b0;
   endtask

   task automatic send_tag(input logic [63:0] d, input logic [1:0] resp);
      int n = 0;
      tag_rsp = '{data: d, resp: resp, last: 1'b1};
      tag_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!tag_ready && n < 200);
      if (!tag_ready) timeout_fail("tag");
      @(posedge clk); #1;
      tag_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [127:0] d, input logic [1:0] mresp, input logic [3:0] eid,
                            input logic [1:0] eresp, input logic elast, input logic euser);
      int n = 0;
      r_chan_s e;
      e = '{id: eid, data: d, resp: eresp, last: elast, user: euser};
      exp_q.push_back(e);
      mem_r = '{id: 4'hF, data: d, resp: mresp, last: 1'b0, user: 1'b0};
      mem_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!mem_ready && n < 200);
      if (!mem_ready) timeout_fail("beat");
      @(posedge clk); #1;
      mem_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_slv_valid",  256'(slv_valid),  256'(0));
      check("rst_desc_ready", 256'(desc_ready), 256'(0));
      check("rst_tag_ready",  256'(tag_ready),  256'(0));
      check("rst_mem_ready",  256'(mem_ready),  256'(0));
      check("rst_slv_chan",   256'(slv_r),      256'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_valid", 256'(slv_valid), 256'(0));
      @(posedge clk); #1;

      // Single beat
      send_desc(4'h5, 32'h8000_0010, 8'd0, 3'd4, 8'd0);
      send_tag(64'h2, 2'b00);
      send_beat(128'h1111, 2'b00, 4'h5, 2'b00, 1'b1, 1'b1);

      // Block crossing with second tag word
      send_desc(4'h3, 32'h8000_03E0, 8'd3, 3'd4, 8'd1);
      send_tag(64'hC000_0000_0000_0000, 2'b00);
      send_beat(128'h2001, 2'b00, 4'h3, 2'b00, 1'b0, 1'b1);
      send_beat(128'h2002, 2'b00, 4'h3, 2'b00, 1'b0, 1'b1);
      mem_r = '{id: 4'hF, data: 128'h2003, resp: 2'b00, last: 1'b0, user: 1'b0};
      mem_valid = 1'b1;
      @(negedge clk);
      check("fetch_stall_valid", 256'(slv_valid), 256'(0));
      check("fetch_stall_ready", 256'(mem_ready), 256'(0));
      @(posedge clk); #1;
      send_tag(64'h2, 2'b00);
      send_beat(128'h2003, 2'b00, 4'h3, 2'b00, 1'b0, 1'b0);
      send_beat(128'h2004, 2'b00, 4'h3, 2'b00, 1'b1, 1'b1);

      // Slave ready toggling across an 8-beat burst
      pattern = 8'hA5;
      send_desc(4'h7, 32'h8000_0000, 8'd7, 3'd4, 8'd0);
      send_tag(64'h00A5, 2'b00);
      done = 1'b0;
      fork
         begin
            for (int b = 0; b < 8; b++)
               send_beat(128'h3000 + 128'(b), 2'b00, 4'h7, 2'b00, (b == 7), pattern[b]);
            done = 1'b1;
         end
         begin
            for (int c = 0; c < 2000 && !done; c++) begin
               @(posedge clk); #1;
               slv_ready = ~slv_ready;
            end
         end
      join
      slv_ready = 1'b1;
      @(negedge clk);
      check("toggle_queue_empty", 256'(exp_q.size()), 256'(0));
      @(posedge clk); #1;

      // Memory beat waiting on the tag word
      send_desc(4'h9, 32'h8000_0020, 8'd0, 3'd4, 8'd0);
      mem_r = '{id: 4'hF, data: 128'h4444, resp: 2'b00, last: 1'b1, user: 1'b0};
      mem_valid = 1'b1;
      for (int w = 0; w < 5; w++) begin
         @(negedge clk);
         check("early_mem_ready", 256'(mem_ready), 256'(0));
         check("early_slv_valid", 256'(slv_valid), 256'(0));
      end
      @(posedge clk); #1;
      send_tag(64'h4, 2'b00);
      send_beat(128'h4444, 2'b00, 4'h9, 2'b00, 1'b1, 1'b1);

      // Tag word read error
      send_desc(4'h2, 32'h8000_0000, 8'd0, 3'd4, 8'd0);
      send_tag(64'h1, 2'b10);
`ifdef AXI_TAGCTRL_R_TAGERR_EN
      send_beat(128'h5555, 2'b00, 4'h2, 2'b10, 1'b1, 1'b0);
`else
      send_beat(128'h5555, 2'b00, 4'h2, 2'b00, 1'b1, 1'b1);
`endif

      // Narrow transfer plus a leftover tag word to drain
      send_desc(4'hA, 32'h8000_0044, 8'd0, 3'd2, 8'd1);
      send_tag(64'h10, 2'b00);
      send_beat(128'h6666, 2'b00, 4'hA, 2'b00, 1'b1, 1'b1);
      send_tag(64'hFFFF_FFFF_FFFF_FFFF, 2'b00);

      // Reset in the middle of a burst
      send_desc(4'h6, 32'h8000_0100, 8'd3, 3'd4, 8'd0);
      send_tag(64'hFFFF_FFFF_FFFF_FFFF, 2'b00);
      send_beat(128'h7001, 2'b00, 4'h6, 2'b00, 1'b0, 1'b1);
      send_beat(128'h7002, 2'b00, 4'h6, 2'b00, 1'b0, 1'b1);
      rst_n = 1'b0;
      mem_r = '{id: 4'hF, data: 128'h7003, resp: 2'b00, last: 1'b0, user: 1'b0};
      mem_valid = 1'b1;
      @(negedge clk);
      check("midrst_slv_valid",  256'(slv_valid),  256'(0));
      check("midrst_mem_ready",  256'(mem_ready),  256'(0));
      check("midrst_tag_ready",  256'(tag_ready),  256'(0));
      check("midrst_desc_ready", 256'(desc_ready), 256'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_next_valid", 256'(slv_valid), 256'(0));
      @(posedge clk); #1;
      mem_valid = 1'b0;
      send_desc(4'h1, 32'h8000_0030, 8'd0, 3'd4, 8'd0);
      send_tag(64'h8, 2'b00);
      send_beat(128'h8888, 2'b00, 4'h1, 2'b00, 1'b1, 1'b1);

      repeat (3) @(negedge clk);
      check("final_queue_empty", 256'(exp_q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
